fg_spi_config_regs: RTL and testbench
=====================================

// Module: fg_spi_config_regs
// PURPOSE
// - SPI-slave configuration front end directly upstream of the function generator core.
// - Assembles the 64-bit config bus (byte-addressed shadow registers) and drives the core's outputEnable.
// - Transfers shadow to the active bus atomically on commit, optionally aligned to the core's sample strobe,
//   so that no waveform sample is computed from a half-updated configuration.
// PARAMETERS
// - CONFIG_REG_BITWIDTH  64     width of CR_bus_o; fixed at 8 bytes
// - CR_RESET             64'h0  reset value of shadow and active config
// - COMMIT_ON_STROBE     1      1: apply commit on sampleStrobe_i; 0: apply the next clk
// - DEVICE_ID            8'hF6  value returned by a read of addr 0x7F
// PORTS
// - clk_i            in   1   system clock
// - rstn_i           in   1   asynchronous, active-low reset
// - spi_sclk_i       in   1   SPI clock, mode 0, async to clk_i, f_sclk <= f_clk/8
// - spi_csn_i        in   1   SPI chip select, active low, async
// - spi_mosi_i       in   1   SPI data in, async
// - spi_miso_o       out  1   SPI data out, MSB first
// - sampleStrobe_i   in   1   core output-valid strobe (one clk pulse per sample)
// - CR_bus_o         out  64  active config bus to the core
// - outputEnable_o   out  1   core output enable
// - configBusy_o     out  1   commit pending, not yet applied
// BEHAVIOUR
// - Reset: CR_bus_o=CR_RESET, shadow=CR_RESET, outputEnable_o=0, configBusy_o=0, spi_miso_o=0, bit counter=0.
// - Synchronisation: sclk, csn and mosi pass through 2-FF synchronisers; edges are detected in the clk domain.
// - Frame: 16 bits, MSB first, sampled on sclk rise: [15]=W(1)/R(0), [14:8]=addr, [7:0]=data.
// - Bit counter: counts sclk rises while csn=0; csn high clears it.
//   - A partial frame (csn rises before 16 bits) is discarded and causes no write.
//   - After 16 bits the counter wraps to 0, so back-to-back frames within one csn-low burst are legal.
// - Address map:
//   - 0x00..0x07: shadow byte n = CR bits [8n+7:8n].
//   - 0x08 CTRL (write): bit0 commit (self-clearing), bit1 outputEnable.
//   - 0x08 (read): {5'b0, configBusy, outputEnable, 1'b0}.
//   - 0x7F: read-only DEVICE_ID.
//   - Other addresses: writes ignored, reads return 0x00.
// - Write: the shadow/CTRL update happens 1 clk after the synchronised 16th rise.
//   - outputEnable_o changes on that same clk, independent of any commit.
// - Read:
//   - The read byte is latched 1 clk after the synchronised 8th rise.
//   - spi_miso_o shifts out on each synchronised sclk fall, starting with the fall after bit 8.
//   - spi_miso_o is 0 during the cmd/addr phase and while csn=1.
//   - Reads of 0x00..0x07 return shadow, not active, content.
// - Commit:
//   - Writing CTRL.bit0=1 sets pending (configBusy_o=1).
//   - COMMIT_ON_STROBE=0: CR_bus_o<=shadow on the next clk.
//   - COMMIT_ON_STROBE=1: CR_bus_o<=shadow on the first clk with sampleStrobe_i=1, or on the next clk if outputEnable_o=0.
//   - configBusy_o clears in the same clk as the transfer.
// - Simultaneous events:
//   - Commit write and strobe in the same clk: apply in that clk.
//   - Shadow written while pending: the new value is included in the transfer.
//   - A second commit while pending has no extra effect.
// - CR_bus_o changes only as a whole 64-bit load; it never changes byte-wise.
// - Reset mid-frame or mid-pending: everything returns to reset values and the pending commit is lost.
// STRUCTURE
// - Package fg_cfg_pkg holds: ADDR_CR0..ADDR_CR7, ADDR_CTRL=7'h08, ADDR_ID=7'h7F, FRAME_BITS=16, CTRL bit indices.
// - Sub-module fg_sync_edge: 2-FF synchroniser with rise/fall pulse outputs; one instance per SPI input.
// - Top level: frame shift register and counter, register file, read mux, commit FSM with states IDLE and PENDING.
// TESTING
// - Write 0x00..0x07 = 0x11..0x88, no commit -> CR_bus_o stays CR_RESET, read 0x03 returns 0x44.
// - Then write CTRL=0x03 with COMMIT_ON_STROBE=1 and strobe pulsed 20 clks later:
//   - outputEnable_o=1 at once, configBusy_o=1.
//   - CR_bus_o=64'h8877665544332211 exactly on the strobe clk, configBusy_o=0.
// - csn raised after 11 bits of a write to 0x05 -> shadow unchanged; the next full frame decodes correctly.
// - Single csn-low burst of 3 frames (write 0x00=0xAA, write 0x01=0xBB, read 0x7F) -> both writes land, MISO returns 0xF6.
// - Write 0x40=0x55, then read 0x40 -> no state change, MISO returns 0x00.
// - rstn_i asserted while pending with strobe never pulsed -> all outputs return to reset values, configBusy_o=0, no later transfer.

Source files
------------

// File: rtl/fg_cfg_pkg.sv
// Shared constants and types for the function-generator SPI configuration front end.
package fg_cfg_pkg;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

  localparam logic [ADDR_W-1:0] ADDR_CR0  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_CR1  = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_CR2  = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_CR3  = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_CR4  = 7'h04;
  localparam logic [ADDR_W-1:0] ADDR_CR5  = 7'h05;
  localparam logic [ADDR_W-1:0] ADDR_CR6  = 7'h06;
  localparam logic [ADDR_W-1:0] ADDR_CR7  = 7'h07;
  localparam logic [ADDR_W-1:0] ADDR_CTRL = 7'h08;
  localparam logic [ADDR_W-1:0] ADDR_ID   = 7'h7F;

  localparam int unsigned CTRL_COMMIT_BIT = 0;
  localparam int unsigned CTRL_OE_BIT     = 1;
  localparam int unsigned CTRL_BUSY_BIT   = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_e;

  // One complete SPI frame as it appears MSB first on the wire.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } spi_frame_t;

endpackage

// File: rtl/fg_spi_config_regs_if.sv
// SPI slave pin bundle between the host-side master and the config front end.
interface fg_spi_config_regs_if;

  logic spi_sclk;
  logic spi_csn;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sclk, output spi_csn, output spi_mosi, input spi_miso);
  modport slave  (input spi_sclk, input spi_csn, input spi_mosi, output spi_miso);

endinterface

// File: rtl/fg_sync_edge.sv
// Two-flop synchroniser for one async input plus single-clk rise/fall pulses.
module fg_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_c,
  output logic fall_c
);

  logic [2:0] sync_q;

  // Stages 0/1 synchronise, stage 2 holds the previous synchronised value.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= {3{RST_VAL}};
    else         sync_q <= {sync_q[1:0], d_i};
  end

  assign q_o    = sync_q[1];
  assign rise_c = sync_q[1] & ~sync_q[2];
  assign fall_c = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/fg_spi_config_regs.sv
// SPI-slave config front end: shadow registers, CTRL, read-back and atomic commit to the core.
module fg_spi_config_regs
  import fg_cfg_pkg::*;
#(
  parameter int unsigned                    CONFIG_REG_BITWIDTH = 64,
  parameter logic [CONFIG_REG_BITWIDTH-1:0] CR_RESET            = '0,
  parameter bit                             COMMIT_ON_STROBE    = 1'b1,
  parameter logic [DATA_W-1:0]              DEVICE_ID           = 8'hF6
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  fg_spi_config_regs_if.slave            spi,
  input  logic                           sampleStrobe_i,
  output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
  output logic                           outputEnable_o,
  output logic                           configBusy_o
);

  logic sclk_rise, sclk_fall, csn_q, mosi_q;
  logic unused_sclk_q, unused_csn_rise, unused_csn_fall, unused_mosi_rise, unused_mosi_fall;

  logic [CNT_W-1:0]                bit_cnt_q;
  logic [FRAME_BITS-2:0]           shift_q;
  spi_frame_t                      frame_c;
  logic                            frame_done_c, addr_done_c, wr_frame_c;
  logic [ADDR_W-1:0]               rd_addr_c;
  logic                            rd_cmd_c;
  logic [DATA_W-1:0]               rd_data_c, tx_q;
  logic                            miso_q;
  logic [CONFIG_REG_BITWIDTH-1:0]  shadow_q, shadow_nxt, cr_q;
  logic                            oe_q, ctrl_wr_c, commit_req_c, cr_load_c;
  commit_state_e                   state_q, state_nxt;

  fg_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(spi.spi_sclk),
    .q_o(unused_sclk_q), .rise_c(sclk_rise), .fall_c(sclk_fall));

  fg_sync_edge #(.RST_VAL(1'b1)) u_sync_csn (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(spi.spi_csn),
    .q_o(csn_q), .rise_c(unused_csn_rise), .fall_c(unused_csn_fall));

  fg_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(spi.spi_mosi),
    .q_o(mosi_q), .rise_c(unused_mosi_rise), .fall_c(unused_mosi_fall));

  // Current bit joined to the bits already shifted in; complete only on the 16th rise.
  assign frame_c      = {shift_q, mosi_q};
  assign frame_done_c = sclk_rise & ~csn_q & (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
  assign addr_done_c  = sclk_rise & ~csn_q & (bit_cnt_q == CNT_W'(FRAME_BITS / 2 - 1));
  assign rd_cmd_c     = ~shift_q[ADDR_W-1];
  assign rd_addr_c    = {shift_q[ADDR_W-2:0], mosi_q};
  assign wr_frame_c   = frame_done_c & frame_c.wr;
  assign ctrl_wr_c    = wr_frame_c & (frame_c.addr == ADDR_CTRL);
  assign commit_req_c = ctrl_wr_c & frame_c.data[CTRL_COMMIT_BIT];

  // Frame shifter and bit counter; wraps after 16 so frames may run back to back.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (csn_q) begin
      bit_cnt_q <= '0;
    end else if (sclk_rise) begin
      shift_q   <= frame_c[FRAME_BITS-2:0];
      bit_cnt_q <= bit_cnt_q + CNT_W'(1);
    end
  end

  // Read mux; cfg bytes return shadow content.
  always_comb begin
    rd_data_c = '0;
    if (rd_addr_c <= ADDR_CR7) begin
      rd_data_c = shadow_q[{rd_addr_c[2:0], 3'b000} +: DATA_W];
    end else if (rd_addr_c == ADDR_CTRL) begin
      rd_data_c[CTRL_OE_BIT]   = oe_q;
      rd_data_c[CTRL_BUSY_BIT] = configBusy_o;
    end else if (rd_addr_c == ADDR_ID) begin
      rd_data_c = DEVICE_ID;
    end
  end

  // MISO: read byte latched after the address, shifted out on falls of the data phase.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_q   <= '0;
      miso_q <= 1'b0;
    end else if (csn_q) begin
      tx_q   <= '0;
      miso_q <= 1'b0;
    end else if (addr_done_c) begin
      tx_q <= rd_cmd_c ? rd_data_c : '0;
    end else if (sclk_fall) begin
      if (bit_cnt_q[CNT_W-1]) begin
        miso_q <= tx_q[DATA_W-1];
        tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
      end else begin
        miso_q <= 1'b0;
      end
    end
  end

  // Shadow view including a write landing this clk, so a same-clk commit sees it.
  always_comb begin
    shadow_nxt = shadow_q;
    if (wr_frame_c && (frame_c.addr <= ADDR_CR7)) begin
      shadow_nxt[{frame_c.addr[2:0], 3'b000} +: DATA_W] = frame_c.data;
    end
  end

  // Register file and active bus; the active bus only ever loads as a whole word.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shadow_q <= CR_RESET;
      cr_q     <= CR_RESET;
      oe_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_nxt;
      if (ctrl_wr_c) oe_q <= frame_c.data[CTRL_OE_BIT];
      if (cr_load_c) cr_q <= shadow_nxt;
    end
  end

  // Commit FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_nxt;
  end

  // Commit FSM: wait for the sample strobe unless strobe alignment is off or the core is disabled.
  always_comb begin
    state_nxt = state_q;
    cr_load_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (commit_req_c) begin
          if (COMMIT_ON_STROBE && sampleStrobe_i) cr_load_c = 1'b1;
          else                                   state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (!COMMIT_ON_STROBE || sampleStrobe_i || !oe_q) begin
          cr_load_c = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign spi.spi_miso   = miso_q;
  assign CR_bus_o       = cr_q;
  assign outputEnable_o = oe_q;
  assign configBusy_o   = (state_q == ST_PENDING);

endmodule

// File: tb/tb_fg_spi_config_regs.sv
// Bench for fg_spi_config_regs: directed scenarios plus random SPI traffic against a register-level model.
module tb_fg_spi_config_regs;

  localparam int unsigned HALF = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        strobe;
  logic [63:0] cr;
  logic        oe;
  logic        busy;

  fg_spi_config_regs_if spi_if ();

  fg_spi_config_regs dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .spi            (spi_if),
    .sampleStrobe_i (strobe),
    .CR_bus_o       (cr),
    .outputEnable_o (oe),
    .configBusy_o   (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: eight shadow bytes, active word, enable flag, pending-commit flag.
  logic [7:0]  m_sh [8];
  logic [63:0] m_cr;
  logic        m_oe;
  logic        m_pend;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_word();
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = m_sh[i];
    return w;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_sh[i] = 8'h00;
    m_cr = 64'h0; m_oe = 1'b0; m_pend = 1'b0;
  endtask

  // With the core disabled a pending commit cannot wait for a strobe.
  task automatic m_settle();
    if (m_pend && !m_oe) begin m_cr = m_word(); m_pend = 1'b0; end
  endtask

  task automatic m_write(input logic [6:0] a, input logic [7:0] d);
    if (a < 7'd8) m_sh[a[2:0]] = d;
    else if (a == 7'h08) begin
      m_oe = d[1];
      if (d[0]) m_pend = 1'b1;
    end
    m_settle();
  endtask

  task automatic m_strobe();
    if (m_pend) begin m_cr = m_word(); m_pend = 1'b0; end
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a);
    if (a < 7'd8)   return m_sh[a[2:0]];
    if (a == 7'h08) return {5'b0, m_pend, m_oe, 1'b0};
    if (a == 7'h7F) return 8'hF6;
    return 8'h00;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    spi_if.spi_csn = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    tick(HALF);
    spi_if.spi_csn = 1'b1;
    tick(HALF);
  endtask

  // Drive the top n bits of f; collect MISO before rises 9..16 and flag any 1 seen before rise 9.
  task automatic send_bits(input logic [15:0] f, input int n, output logic [7:0] rd, output logic early);
    rd = 8'h00; early = 1'b0;
    for (int i = 15; i > 15 - n; i--) begin
      spi_if.spi_mosi = f[i];
      tick(HALF);
      if (i < 8) rd = {rd[6:0], spi_if.spi_miso};
      else       early = early | spi_if.spi_miso;
      spi_if.spi_sclk = 1'b1;
      tick(HALF);
      spi_if.spi_sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic wr, input logic [6:0] a, input logic [7:0] d, output logic [7:0] rd);
    logic early;
    send_bits({wr, a, d}, 16, rd, early);
    check("miso_cmd_phase", 64'(early), 64'h0);
    if (wr) m_write(a, d);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] rd;
    cs_low(); frame(1'b1, a, d, rd); cs_high();
  endtask

  task automatic do_read(input string tag, input logic [6:0] a);
    logic [7:0] rd;
    cs_low(); frame(1'b0, a, 8'h00, rd); cs_high();
    check(tag, 64'(rd), 64'(m_read(a)));
  endtask

  task automatic check_state(input string tag);
    check({tag, "_cr"},   cr,                   m_cr);
    check({tag, "_oe"},   64'(oe),              64'(m_oe));
    check({tag, "_busy"}, 64'(busy),            64'(m_pend));
    check({tag, "_miso"}, 64'(spi_if.spi_miso), 64'h0);
  endtask

  task automatic pulse_strobe();
    @(negedge clk) strobe = 1'b1;
    @(negedge clk) strobe = 1'b0;
    tick(2);
  endtask

  initial begin
    logic [7:0] rd;
    logic       early;
    logic [7:0] d;
    logic [6:0] a;
    int         op, r;

    rstn = 1'b0; strobe = 1'b0;
    spi_if.spi_sclk = 1'b0; spi_if.spi_csn = 1'b1; spi_if.spi_mosi = 1'b0;
    m_reset();
    tick(3);
    check("reset_cr", cr, 64'h0);
    check("reset_oe", 64'(oe), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_miso", 64'(spi_if.spi_miso), 64'h0);
    rstn = 1'b1;
    tick(4);

    // Shadow fill without commit leaves the active bus alone.
    for (int i = 0; i < 8; i++) do_write(7'(i), 8'(8'h11 * (i + 1)));
    check_state("fill");
    do_read("read_cr3", 7'h03);

    // Commit with enable: held until the strobe, then applied on exactly that clk.
    do_write(7'h08, 8'h03);
    check_state("commit_wait");
    check("commit_busy_set", 64'(busy), 64'h1);
    tick(20);
    strobe = 1'b1;
    check("pre_strobe_cr", cr, 64'h0);
    @(posedge clk); #1;
    check("strobe_cr", cr, 64'h8877665544332211);
    check("strobe_busy", 64'(busy), 64'h0);
    m_strobe();
    @(negedge clk) strobe = 1'b0;
    check_state("post_strobe");

    // Aborted frame after 11 bits writes nothing; the following frame still decodes.
    cs_low();
    send_bits({1'b1, 7'h05, 8'hEE}, 11, rd, early);
    cs_high();
    do_read("partial_keep", 7'h05);
    do_write(7'h05, 8'h5A);
    do_read("after_partial", 7'h05);

    // Three frames in one chip-select burst.
    cs_low();
    frame(1'b1, 7'h00, 8'hAA, rd);
    frame(1'b1, 7'h01, 8'hBB, rd);
    frame(1'b0, 7'h7F, 8'h00, rd);
    cs_high();
    check("burst_id", 64'(rd), 64'hF6);
    do_read("burst_b0", 7'h00);
    do_read("burst_b1", 7'h01);

    // Unmapped address.
    do_write(7'h40, 8'h55);
    check_state("unmapped_wr");
    do_read("unmapped_rd", 7'h40);
    do_read("ctrl_rd", 7'h08);

    // Random traffic.
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      d  = 8'($urandom);
      case (op)
        0: do_write(7'($urandom_range(0, 7)), d);
        1: do_write(7'h08, {6'b0, 2'($urandom_range(0, 3))});
        2: do_write(7'($urandom_range(9, 126)), d);
        default: begin
          r = $urandom_range(0, 10);
          if (r <= 8)       a = 7'(r);
          else if (r == 9)  a = 7'h7F;
          else              a = 7'($urandom_range(9, 126));
          do_read("rnd_read", a);
        end
      endcase
      check_state("rnd");
      if ($urandom_range(0, 1) == 1) begin
        pulse_strobe();
        m_strobe();
        check_state("rnd_strobe");
      end
    end

    // Reset while a commit is pending and a frame is half sent.
    do_write(7'h06, 8'hC3);
    do_write(7'h08, 8'h03);
    check("rst_pre_busy", 64'(busy), 64'h1);
    cs_low();
    send_bits({1'b1, 7'h02, 8'h99}, 5, rd, early);
    rstn = 1'b0;
    tick(2);
    m_reset();
    check_state("in_reset");
    spi_if.spi_csn = 1'b1;
    tick(3);
    rstn = 1'b1;
    tick(50);
    pulse_strobe();
    check_state("after_reset");
    do_read("after_reset_b6", 7'h06);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
